// File: rtl/hyperbus_pkg.sv
// Shared HyperBus types: configuration, transfer descriptor, splitter state
// and the chip-size helper used by the transfer splitter.
package hyperbus_pkg;

  localparam int unsigned HyperBurstWidth = 16;

  typedef struct packed {
    logic [3:0]  t_latency_access;
    logic        en_latency_additional;
    logic [15:0] t_burst_max;
    logic [3:0]  t_read_write_recovery;
    logic [4:0]  address_mask_msb;
  } hyper_cfg_t;

  typedef struct packed {
    logic                       write;
    logic                       address_space;
    logic                       burst_type;
    logic [31:0]                address;
    logic [HyperBurstWidth-1:0] burst;
  } hyper_tf_t;

  typedef enum logic {
    SplitIdle = 1'b0,
    SplitEmit = 1'b1
  } hyper_split_state_t;

  // Bytes per chip; 33 bits so that msb=31 yields 2^32 without overflow.
  function automatic logic [32:0] hyper_chip_bytes(input logic [4:0] msb);
    return 33'd1 << ({1'b0, msb} + 6'd1);
  endfunction

endpackage

// File: rtl/hyperbus_chunk_calc.sv
// Combinational chunk sizing: min(remaining, burst limit, words to chip end)
// plus one-hot chip select decoded from the current address.
module hyperbus_chunk_calc
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned BlenWidth = HyperBurstWidth
) (
  input  logic [31:0]          addr_i,
  input  logic [BlenWidth-1:0] rem_i,
  input  logic [15:0]          burst_max_i,
  input  logic [4:0]           msb_i,
  input  logic                 burst_type_i,
  output logic [BlenWidth-1:0] chunk_o,
  output logic [NumChips-1:0]  cs_o,
  output logic                 last_o
);

  logic [32:0]          chip_bytes_s;
  logic [32:0]          offset_s;
  logic [32:0]          bnd_full_s;
  logic [32:0]          chip_idx_s;
  logic [BlenWidth-1:0] bnd_s;
  logic [BlenWidth-1:0] max_s;
  logic [BlenWidth-1:0] lim_s;

  always_comb begin
    chip_bytes_s = hyper_chip_bytes(msb_i);
    // Bit 0 is masked so the distance to the chip end is always >= one word.
    offset_s     = {1'b0, addr_i & 32'hFFFF_FFFE} & (chip_bytes_s - 33'd1);
    bnd_full_s   = (chip_bytes_s - offset_s) >> 1;
    if (|(bnd_full_s >> BlenWidth)) begin
      bnd_s = '1;
    end else begin
      bnd_s = bnd_full_s[BlenWidth-1:0];
    end
    if (burst_max_i == 16'd0) begin
      max_s = '1;
    end else begin
      max_s = BlenWidth'(burst_max_i);
    end
    lim_s = (bnd_s < max_s) ? bnd_s : max_s;
    if (burst_type_i) begin
      chunk_o = (rem_i < lim_s) ? rem_i : lim_s;
    end else begin
      chunk_o = rem_i;
    end
    last_o     = (chunk_o == rem_i);
    chip_idx_s = ({1'b0, addr_i} >> ({1'b0, msb_i} + 6'd1)) & 33'(NumChips - 1);
    cs_o       = '0;
    for (int unsigned i = 0; i < NumChips; i++) begin
      cs_o[i] = (chip_idx_s == 33'(i));
    end
  end

endmodule

// File: rtl/hyperbus_tf_splitter.sv
// Splits one HyperBus transfer into chunks bounded by t_burst_max and chip
// boundaries, each tagged with a one-hot chip select and a last flag.
module hyperbus_tf_splitter
  import hyperbus_pkg::*;
#(
  parameter int unsigned NumChips  = 2,
  parameter int unsigned BlenWidth = HyperBurstWidth
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  hyper_cfg_t          cfg_i,
  input  hyper_tf_t           tf_i,
  input  logic                tf_valid_i,
  output logic                tf_ready_o,
  output hyper_tf_t           tf_o,
  output logic [NumChips-1:0] cs_o,
  output logic                last_o,
  output logic                tf_valid_o,
  input  logic                tf_ready_i
);

  hyper_split_state_t   state_q, state_d;
  logic                 write_q, write_d;
  logic                 aspace_q, aspace_d;
  logic                 btype_q, btype_d;
  logic [31:0]          addr_q, addr_d;
  logic [BlenWidth-1:0] rem_q, rem_d;
  logic [15:0]          tbm_q, tbm_d;
  logic [4:0]           msb_q, msb_d;

  logic [BlenWidth-1:0] chunk_s;
  logic [NumChips-1:0]  cs_s;
  logic                 last_s;
  logic                 unused_cfg_s;

  assign unused_cfg_s = ^{cfg_i.t_latency_access, cfg_i.en_latency_additional,
                          cfg_i.t_read_write_recovery};

  hyperbus_chunk_calc #(
    .NumChips  (NumChips),
    .BlenWidth (BlenWidth)
  ) i_chunk_calc (
    .addr_i       (addr_q),
    .rem_i        (rem_q),
    .burst_max_i  (tbm_q),
    .msb_i        (msb_q),
    .burst_type_i (btype_q),
    .chunk_o      (chunk_s),
    .cs_o         (cs_s),
    .last_o       (last_s)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    aspace_d   = aspace_q;
    btype_d    = btype_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    tbm_d      = tbm_q;
    msb_d      = msb_q;
    tf_ready_o = 1'b0;
    tf_valid_o = 1'b0;
    tf_o       = '0;
    cs_o       = '0;
    last_o     = 1'b0;
    case (state_q)
      SplitIdle: begin
        tf_ready_o = 1'b1;
        // Zero-length transfers are consumed without producing a chunk.
        if (tf_valid_i && (tf_i.burst != '0)) begin
          write_d  = tf_i.write;
          aspace_d = tf_i.address_space;
          btype_d  = tf_i.burst_type;
          addr_d   = tf_i.address;
          rem_d    = BlenWidth'(tf_i.burst);
          tbm_d    = cfg_i.t_burst_max;
          msb_d    = cfg_i.address_mask_msb;
          state_d  = SplitEmit;
        end else begin
          state_d = SplitIdle;
        end
      end
      SplitEmit: begin
        tf_valid_o           = 1'b1;
        tf_o.write           = write_q;
        tf_o.address_space   = aspace_q;
        tf_o.burst_type      = btype_q;
        tf_o.address         = addr_q;
        tf_o.burst           = HyperBurstWidth'(chunk_s);
        cs_o                 = cs_s;
        last_o               = last_s;
        if (tf_ready_i) begin
          rem_d  = rem_q - chunk_s;
          addr_d = addr_q + (32'(chunk_s) << 1);
          if (last_s) begin
            state_d = SplitIdle;
          end else begin
            state_d = SplitEmit;
          end
        end else begin
          state_d = SplitEmit;
        end
      end
      default: begin
        state_d = SplitIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= SplitIdle;
      write_q  <= 1'b0;
      aspace_q <= 1'b0;
      btype_q  <= 1'b0;
      addr_q   <= 32'd0;
      rem_q    <= '0;
      tbm_q    <= 16'd0;
      msb_q    <= 5'd0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      aspace_q <= aspace_d;
      btype_q  <= btype_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      tbm_q    <= tbm_d;
      msb_q    <= msb_d;
    end
  end

endmodule

// File: tb/tb_hyperbus_tf_splitter.sv
// Self-checking bench: table of transfers with expected chunks fed through a
// scoreboard queue, plus sequences for backpressure, drop and reset abort.
module tb_hyperbus_tf_splitter;
  import hyperbus_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  hyper_cfg_t cfg_i;
  hyper_tf_t  tf_i;
  logic       tf_valid_i;
  logic       tf_ready_o;
  hyper_tf_t  tf_o;
  logic [1:0] cs_o;
  logic       last_o;
  logic       tf_valid_o;
  logic       tf_ready_i;

  always #5 clk_i = ~clk_i;

  hyperbus_tf_splitter #(.NumChips(2), .BlenWidth(HyperBurstWidth)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .cfg_i      (cfg_i),
    .tf_i       (tf_i),
    .tf_valid_i (tf_valid_i),
    .tf_ready_o (tf_ready_o),
    .tf_o       (tf_o),
    .cs_o       (cs_o),
    .last_o     (last_o),
    .tf_valid_o (tf_valid_o),
    .tf_ready_i (tf_ready_i)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] len;
    logic [1:0]  cs;
    logic        last;
    logic        btype;
  } chunk_t;

  typedef struct packed {
    logic [31:0]       addr;
    logic [15:0]       burst;
    logic              btype;
    logic [15:0]       tbm;
    logic [4:0]        msb;
    logic [1:0]        nexp;
    logic [2:0][31:0]  e_addr;
    logic [2:0][15:0]  e_len;
    logic [2:0][1:0]   e_cs;
  } vec_t;

  localparam int NV = 8;
  vec_t   vecs [NV];
  chunk_t exp_q [$];
  int     errors = 0;
  int     checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic vec_t mk_vec(input logic [31:0] a, input logic [15:0] b, input logic bt,
                                  input logic [15:0] tbm, input logic [4:0] msb, input logic [1:0] n,
                                  input logic [31:0] a0, input logic [15:0] l0, input logic [1:0] c0,
                                  input logic [31:0] a1, input logic [15:0] l1, input logic [1:0] c1,
                                  input logic [31:0] a2, input logic [15:0] l2, input logic [1:0] c2);
    vec_t v;
    v.addr = a; v.burst = b; v.btype = bt; v.tbm = tbm; v.msb = msb; v.nexp = n;
    v.e_addr[0] = a0; v.e_len[0] = l0; v.e_cs[0] = c0;
    v.e_addr[1] = a1; v.e_len[1] = l1; v.e_cs[1] = c1;
    v.e_addr[2] = a2; v.e_len[2] = l2; v.e_cs[2] = c2;
    return v;
  endfunction

  task automatic push_vec(input vec_t v);
    chunk_t c;
    for (int k = 0; k < int'(v.nexp); k++) begin
      c.addr  = v.e_addr[k];
      c.len   = v.e_len[k];
      c.cs    = v.e_cs[k];
      c.last  = (k == int'(v.nexp) - 1);
      c.btype = v.btype;
      exp_q.push_back(c);
    end
  endtask

  task automatic monitor();
    chunk_t e;
    forever begin
      @(negedge clk_i);
      if (tf_valid_o === 1'b1 && tf_ready_i === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_chunk: actual addr=%0h burst=%0d required no chunk",
                   tf_o.address, tf_o.burst);
        end else begin
          e = exp_q.pop_front();
          check("chunk_addr", 64'(tf_o.address), 64'(e.addr));
          check("chunk_len", 64'(tf_o.burst), 64'(e.len));
          check("chunk_cs", 64'(cs_o), 64'(e.cs));
          check("chunk_last", 64'(last_o), 64'(e.last));
          check("chunk_btype", 64'(tf_o.burst_type), 64'(e.btype));
        end
      end
    end
  endtask

  // Waits for ready, presents one transfer for a single accepting edge.
  task automatic send(input logic [31:0] a, input logic [15:0] b, input logic bt,
                      input logic [15:0] tbm, input logic [4:0] msb);
    int n = 0;
    while (tf_ready_o !== 1'b1 && n < 200) begin
      @(posedge clk_i); #1; n++;
    end
    if (n >= 200) check("ready_timeout", 64'(tf_ready_o), 64'd1);
    cfg_i.t_burst_max      = tbm;
    cfg_i.address_mask_msb = msb;
    tf_i.write             = 1'b1;
    tf_i.address_space     = 1'b0;
    tf_i.burst_type        = bt;
    tf_i.address           = a;
    tf_i.burst             = b;
    tf_valid_i             = 1'b1;
    @(posedge clk_i); #1;
    tf_valid_i = 1'b0;
    if (b != 16'd0) check("first_chunk_latency", 64'(tf_valid_o), 64'd1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(posedge clk_i); #1; n++;
    end
    check("drain_pending", 64'(exp_q.size()), 64'd0);
    check("idle_after_last", 64'({tf_valid_o, tf_ready_o}), 64'b01);
  endtask

  initial begin
    vecs[0] = mk_vec(32'h0, 16'd40, 1'b1, 16'd16, 5'd25, 2'd3,
                     32'h0, 16'd16, 2'b01, 32'h20, 16'd16, 2'b01, 32'h40, 16'd8, 2'b01);
    vecs[1] = mk_vec(32'h03FF_FFF0, 16'd20, 1'b1, 16'd16, 5'd25, 2'd2,
                     32'h03FF_FFF0, 16'd8, 2'b01, 32'h0400_0000, 16'd12, 2'b10, 32'h0, 16'd0, 2'b00);
    vecs[2] = mk_vec(32'h100, 16'd64, 1'b0, 16'd16, 5'd25, 2'd1,
                     32'h100, 16'd64, 2'b01, 32'h0, 16'd0, 2'b00, 32'h0, 16'd0, 2'b00);
    vecs[3] = mk_vec(32'h100, 16'd300, 1'b1, 16'd0, 5'd25, 2'd1,
                     32'h100, 16'd300, 2'b01, 32'h0, 16'd0, 2'b00, 32'h0, 16'd0, 2'b00);
    vecs[4] = mk_vec(32'h0C00_0000, 16'd4, 1'b1, 16'd16, 5'd25, 2'd1,
                     32'h0C00_0000, 16'd4, 2'b10, 32'h0, 16'd0, 2'b00, 32'h0, 16'd0, 2'b00);
    vecs[5] = mk_vec(32'hFFFF_FFFC, 16'd5, 1'b1, 16'd0, 5'd31, 2'd2,
                     32'hFFFF_FFFC, 16'd2, 2'b01, 32'h0, 16'd3, 2'b01, 32'h0, 16'd0, 2'b00);
    vecs[6] = mk_vec(32'h3FC, 16'd6, 1'b1, 16'd0, 5'd9, 2'd2,
                     32'h3FC, 16'd2, 2'b01, 32'h400, 16'd4, 2'b10, 32'h0, 16'd0, 2'b00);
    vecs[7] = mk_vec(32'h03FF_FFF0, 16'd64, 1'b0, 16'd16, 5'd25, 2'd1,
                     32'h03FF_FFF0, 16'd64, 2'b01, 32'h0, 16'd0, 2'b00, 32'h0, 16'd0, 2'b00);

    rst_ni     = 1'b0;
    cfg_i      = '0;
    tf_i       = '0;
    tf_valid_i = 1'b0;
    tf_ready_i = 1'b1;
    fork
      monitor();
    join_none

    #12;
    check("rst_valid", 64'(tf_valid_o), 64'd0);
    check("rst_ready", 64'(tf_ready_o), 64'd1);
    check("rst_last", 64'(last_o), 64'd0);
    check("rst_cs", 64'(cs_o), 64'd0);
    check("rst_tf", 64'(tf_o), 64'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    @(posedge clk_i); #1;

    for (int v = 0; v < NV; v++) begin
      push_vec(vecs[v]);
      send(vecs[v].addr, vecs[v].burst, vecs[v].btype, vecs[v].tbm, vecs[v].msb);
      wait_drain();
    end

    // Zero-length transfer is dropped.
    send(32'h100, 16'd0, 1'b1, 16'd16, 5'd25);
    for (int i = 0; i < 5; i++) begin
      check("drop_idle", 64'({tf_valid_o, tf_ready_o}), 64'b01);
      @(posedge clk_i); #1;
    end

    // Backpressure with a config change mid-transfer.
    begin
      hyper_tf_t  s_tf;
      logic [1:0] s_cs;
      logic       s_last;
      tf_ready_i = 1'b0;
      push_vec(vecs[0]);
      send(vecs[0].addr, vecs[0].burst, vecs[0].btype, vecs[0].tbm, vecs[0].msb);
      cfg_i.t_burst_max = 16'd4;
      s_tf = tf_o; s_cs = cs_o; s_last = last_o;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk_i); #1;
        check("stall_tf", 64'(tf_o), 64'(s_tf));
        check("stall_cs_last", 64'({cs_o, last_o, tf_valid_o}), 64'({s_cs, s_last, 1'b1}));
      end
      check("stall_len", 64'(tf_o.burst), 64'd16);
      tf_ready_i = 1'b1;
      wait_drain();
    end

    // Reset after the first chunk aborts the rest of the transfer.
    begin
      int n = 0;
      push_vec(vecs[0]);
      send(vecs[0].addr, vecs[0].burst, vecs[0].btype, vecs[0].tbm, vecs[0].msb);
      while (exp_q.size() > 2 && n < 20) begin
        @(negedge clk_i); #1; n++;
      end
      check("first_chunk_seen", 64'(exp_q.size()), 64'd2);
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      #1;
      check("abort_valid_ready", 64'({tf_valid_o, tf_ready_o}), 64'b01);
      check("abort_cs_last", 64'({cs_o, last_o}), 64'd0);
      exp_q.delete();
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      for (int i = 0; i < 5; i++) begin
        @(posedge clk_i); #1;
        check("no_stale_chunk", 64'(tf_valid_o), 64'd0);
      end
      push_vec(vecs[1]);
      send(vecs[1].addr, vecs[1].burst, vecs[1].btype, vecs[1].tbm, vecs[1].msb);
      wait_drain();
    end

    repeat (3) @(posedge clk_i);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hyperbus_tf_splitter.md
# hyperbus_tf_splitter

Parametrised transfer splitter between the AXI front-end and the HyperBus PHY. It takes one `hyper_tf_t` and emits one or more `hyper_tf_t` chunks. Each chunk respects the configured maximum burst length (`t_burst_max`, which keeps t_CSM) and never crosses a chip boundary. Each chunk also carries a one-hot chip select for up to `NumChips` devices, which the single-shot transfer path cannot do.

## Interface
Parameters:
- `NumChips`, 2, number of HyperBus devices (chip selects) behind the PHY; power of two, 1..8
- `BlenWidth`, `hyperbus_pkg::HyperBurstWidth`, width of the burst word count

Ports:
- `clk_i`  in  1  clock
- `rst_ni`  in  1  asynchronous active-low reset
- `cfg_i`  in  `hyper_cfg_t`  configuration; only `t_burst_max` and `address_mask_msb` are used
- `tf_i`  in  `hyper_tf_t`  incoming transfer; `address` is a byte address (bit 0 ignored); `burst` is a count of 16-bit words
- `tf_valid_i`  in  1  incoming transfer valid
- `tf_ready_o`  out  1  incoming transfer accepted
- `tf_o`  out  `hyper_tf_t`  outgoing chunk
- `cs_o`  out  `NumChips`  one-hot chip select of the chunk
- `last_o`  out  1  chunk is the final one of its parent transfer
- `tf_valid_o`  out  1  chunk valid
- `tf_ready_i`  in  1  PHY accepts chunk

## Operation
- FSM `SplitIdle`/`SplitEmit`:
  - `SplitIdle`: `tf_ready_o`=1 and `tf_valid_o`=0.
  - On `tf_valid_i`: latch `write`, `address_space`, `burst_type`, `address`, `burst`, `cfg_i.t_burst_max` and `cfg_i.address_mask_msb`, then go to `SplitEmit`.
  - Later `cfg_i` changes do not affect a transfer already in flight.
- `SplitEmit`: `tf_ready_o`=0 and `tf_valid_o`=1. The outputs are driven from the latched registers and the chunk calculation.
- Chunk length is `min(rem, max, bnd)`:
  - `rem` is the remaining word count.
  - `max` is the latched `t_burst_max`, zero-extended. `t_burst_max`=0 means no limit.
  - `bnd` = (2^(msb+1) − (addr & (2^(msb+1)−1))) >> 1.
  - Compute `bnd` at 33-bit width so that msb=31 does not overflow, then saturate to `BlenWidth`.
- Chip index is `addr >> (msb+1)`, truncated to log2(`NumChips`) bits (wraps). `cs_o` is its one-hot decode.
- Chunk fields: `tf_o.address` = current addr, `tf_o.burst` = chunk length; all other fields come from the latched values.
- Wrapped bursts (`burst_type`=0) are never split: one chunk carries the full burst, `cs_o` comes from the start address and `last_o`=1.
- On the handshake `tf_valid_o && tf_ready_i`:
  - rem −= chunk; addr += 2·chunk (32-bit, wraps at 2^32).
  - If rem after the handshake is 0 (`last_o` was 1), return to `SplitIdle`. Otherwise stay in `SplitEmit`.
- An input with `burst`=0 is accepted and dropped: it produces no chunk and the FSM stays in `SplitIdle`.

## Timing
- Reset values: state `SplitIdle`, `tf_valid_o`=0, `tf_ready_o`=1, `last_o`=0, `cs_o`=0, `tf_o`='0, all internal registers 0.
- Latency: input accepted in cycle N → first chunk valid in cycle N+1.
- Throughput: one chunk per cycle while `tf_ready_i`=1. After the last-chunk handshake there is exactly one idle cycle with `tf_ready_o`=1 before the next chunk can appear.
- `tf_o`, `cs_o` and `last_o` hold stable while `tf_valid_o`=1 and `tf_ready_i`=0. `tf_valid_o` never drops without a handshake.
- An asynchronous reset mid-split clears `tf_valid_o` immediately. No further chunks from the aborted transfer are emitted.
- `tf_ready_o` does not depend combinationally on `tf_ready_i`.

## Structure
- Add `hyper_split_state_t` (enum `SplitIdle`, `SplitEmit`) to `hyperbus_pkg`.
- Add a function `hyper_chip_bytes(msb)` to `hyperbus_pkg`, returning a 33-bit `1 << (msb+1)`.
- The chunk computation (min of three values plus chip-index decode) lives in one combinational sub-module, `hyperbus_chunk_calc`.

## Test plan
1. Base config for all scenarios: `NumChips`=2, `t_burst_max`=16, msb=25, linear bursts. Input addr 0x0, burst 40 → chunks (0x00,16), (0x20,16), (0x40,8); `last_o` only on the third; `cs_o`=01 for all three.
2. Chip-boundary crossing: input addr 0x03FF_FFF0, burst 20 → chunk (0x03FF_FFF0, 8, cs=01), then chunk (0x0400_0000, 12, cs=10, last=1).
3. Wrapped burst: addr 0x100, burst 64, `burst_type`=0 → single chunk (0x100, 64), `last_o`=1.
4. No limit and dropped input:
   - `t_burst_max`=0, addr 0x100, burst 300 → single chunk of 300.
   - burst=0 → no `tf_valid_o`, and `tf_ready_o` stays 1.
5. Backpressure and config change:
   - Hold `tf_ready_i`=0 for 5 cycles during scenario 1 → outputs stay stable.
   - Change `t_burst_max` to 4 mid-transfer → chunk lengths are still 16, 16, 8.
6. Reset mid-transfer: assert `rst_ni`=0 after the first chunk of scenario 1 → `tf_valid_o`=0 at once and `tf_ready_o`=1. No remaining chunks appear after release; a new transfer is processed normally.
